// File: rtl/fractional_divider.sv
// fractional_divider
//   Signed fractional divide: quotient = (dividend * 2^WIDTH) / divisor,
//   truncated toward zero. It inverts the fractional multiplier, which keeps
//   the upper WIDTH bits of the 2*WIDTH-bit product.
//   The datapath runs an unsigned restoring division on the operand
//   magnitudes, one quotient bit per cycle over 2*WIDTH cycles. One extra
//   CALC cycle then applies the sign and saturates from registered values.
//   xDone therefore pulses 2*WIDTH+1 cycles after the accepting edge.
//
// Handshake: the request is accepted on a rising edge where xStart=1 and the
//   FSM is in IDLE. Operands are captured on that edge. xStart is ignored
//   while xBusy=1 (CALC and DONE), and requests are never queued. xDone is
//   high for exactly one cycle, and xQuotient/xOverflow/xDivZero are valid
//   from that cycle until the next xDone.
//
// Ports:
//   xClk       in   rising-edge clock
//   xReset     in   asynchronous active-high reset (aborts any division)
//   xStart     in   request pulse
//   xDividend  in   signed numerator, WIDTH bits
//   xDivisor   in   signed denominator, WIDTH bits
//   xQuotient  out  signed registered result, WIDTH bits
//   xBusy      out  high in CALC and DONE
//   xDone      out  one-cycle result-valid pulse
//   xOverflow  out  result saturated
//   xDivZero   out  divisor was zero
//   xState     out  FSM state (0 IDLE, 1 CALC, 2 DONE) for observation
module fractional_divider #(
  parameter int WIDTH = 16
) (
  input  logic                    xClk,
  input  logic                    xReset,
  input  logic                    xStart,
  input  logic signed [WIDTH-1:0] xDividend,
  input  logic signed [WIDTH-1:0] xDivisor,
  output logic signed [WIDTH-1:0] xQuotient,
  output logic                    xBusy,
  output logic                    xDone,
  output logic                    xOverflow,
  output logic                    xDivZero,
  output logic [1:0]              xState
);

  localparam int CW = $clog2(2*WIDTH+1);
  localparam logic [CW-1:0]      LAST    = CW'(2*WIDTH);
  localparam logic [WIDTH-1:0]   ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]   Q_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0]   Q_MIN   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [2*WIDTH-1:0] POS_LIM = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [2*WIDTH-1:0] NEG_LIM = {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]      cnt;      // 0..2W-1: iterations, 2W: finalize
  logic [2*WIDTH-1:0] num;      // magnitude numerator, consumed MSB first
  logic [2*WIDTH-1:0] quo;      // unsigned magnitude quotient
  logic [WIDTH-1:0]   rem;      // partial remainder, always < den
  logic [WIDTH-1:0]   den;      // divisor magnitude
  logic               a_neg;
  logic               a_zero;
  logic               neg_res;
  logic               div_zero;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     trial;
  logic [WIDTH:0]     diff;
  logic               fits;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   res_q;
  logic               res_ovf;

  // The magnitude of the most negative value, 2^(WIDTH-1), still fits in
  // WIDTH unsigned bits, so no extra magnitude bit is carried.
  always_comb begin
    a_mag = xDividend[WIDTH-1] ? ($unsigned(~xDividend) + ONE) : $unsigned(xDividend);
    b_mag = xDivisor[WIDTH-1]  ? ($unsigned(~xDivisor) + ONE)  : $unsigned(xDivisor);
  end

  // One restoring step: bring down the next numerator bit, then subtract
  // the divisor if it fits.
  always_comb begin
    trial    = {rem, num[2*WIDTH-1]};
    diff     = trial - {1'b0, den};
    fits     = (trial >= {1'b0, den});
    rem_next = fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
  end

  // Sign application and saturation. The negative side may reach magnitude
  // 2^(WIDTH-1) exactly, because that value is representable.
  always_comb begin
    res_q   = '0;
    res_ovf = 1'b0;
    if (div_zero) begin
      res_q = a_zero ? '0 : (a_neg ? Q_MIN : Q_MAX);
    end else if (!neg_res) begin
      if (quo > POS_LIM) begin
        res_q   = Q_MAX;
        res_ovf = 1'b1;
      end else begin
        res_q = quo[WIDTH-1:0];
      end
    end else begin
      if (quo > NEG_LIM) begin
        res_q   = Q_MIN;
        res_ovf = 1'b1;
      end else begin
        res_q = ~quo[WIDTH-1:0] + ONE;
      end
    end
  end

  always_ff @(posedge xClk or posedge xReset) begin
    if (xReset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    xBusy      = 1'b0;
    xDone      = 1'b0;
    case (state)
      IDLE: begin
        if (xStart) state_next = CALC;
      end
      CALC: begin
        xBusy = 1'b1;
        if (cnt == LAST) state_next = DONE;
      end
      DONE: begin
        xBusy      = 1'b1;
        xDone      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign xState = state;

  always_ff @(posedge xClk or posedge xReset) begin
    if (xReset) begin
      cnt       <= '0;
      num       <= '0;
      quo       <= '0;
      rem       <= '0;
      den       <= '0;
      a_neg     <= 1'b0;
      a_zero    <= 1'b0;
      neg_res   <= 1'b0;
      div_zero  <= 1'b0;
      xQuotient <= '0;
      xOverflow <= 1'b0;
      xDivZero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (xStart) begin
            cnt      <= '0;
            num      <= {a_mag, {WIDTH{1'b0}}};
            quo      <= '0;
            rem      <= '0;
            den      <= b_mag;
            a_neg    <= xDividend[WIDTH-1];
            a_zero   <= (xDividend == '0);
            neg_res  <= xDividend[WIDTH-1] ^ xDivisor[WIDTH-1];
            div_zero <= (xDivisor == '0);
          end
        end
        CALC: begin
          if (cnt != LAST) begin
            rem <= rem_next;
            num <= {num[2*WIDTH-2:0], 1'b0};
            quo <= {quo[2*WIDTH-2:0], fits};
            cnt <= cnt + 1'b1;
          end else begin
            xQuotient <= res_q;
            xOverflow <= res_ovf;
            xDivZero  <= div_zero;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fractional_divider.sv
module tb_fractional_divider;
  localparam int W = 16;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic signed [W-1:0] dividend = '0;
  logic signed [W-1:0] divisor = '0;
  logic signed [W-1:0] quotient;
  logic                busy, done, ovf, dz;
  logic [1:0]          st;

  int n_tests = 0;
  int n_fail  = 0;

  // expected {div_zero, overflow, quotient}
  logic [W+1:0] exp_q[$];

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic        ovf;
    logic        dz;
  } vec_t;

  vec_t vecs[17];

  fractional_divider #(.WIDTH(W)) dut (
    .xClk(clk), .xReset(rst), .xStart(start),
    .xDividend(dividend), .xDivisor(divisor),
    .xQuotient(quotient), .xBusy(busy), .xDone(done),
    .xOverflow(ovf), .xDivZero(dz), .xState(st)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: exact rational result from wide integer arithmetic.
  function automatic logic [W+1:0] model(input logic signed [15:0] a, input logic signed [15:0] b);
    longint n, t;
    if (b == 0) return {2'b10, (a > 0) ? 16'h7FFF : ((a < 0) ? 16'h8000 : 16'h0000)};
    n = longint'(a) * 65536;
    t = n / longint'(b);
    if (t > 32767)  return {2'b01, 16'h7FFF};
    if (t < -32768) return {2'b01, 16'h8000};
    return {2'b00, 16'(t)};
  endfunction

  // driver: one request, wait for done (bounded), scramble operands meanwhile
  task automatic run_div(input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] q, output logic o, output logic z);
    int lat;
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0;
    dividend = 16'($urandom); divisor = 16'($urandom);
    chk("busy_after_accept", 64'(busy), 64'd1);
    lat = 0;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("done_latency", 64'(lat), 64'd33);
    q = quotient; o = ovf; z = dz;
    @(negedge clk);
    chk("done_single_cycle", 64'({done, busy}), 64'd0);
  endtask

  initial begin
    logic [15:0] q, q1, q2;
    logic o, z;
    logic signed [15:0] ra, rb;
    logic [W+1:0] e;
    int nd, t1, t2, c;

    vecs = '{
      '{16'h1000, 16'h4000, 16'h4000, 1'b0, 1'b0},
      '{16'hF000, 16'h4000, 16'hC000, 1'b0, 1'b0},
      '{16'h0001, 16'h0003, 16'h5555, 1'b0, 1'b0},
      '{16'hFFFF, 16'h0003, 16'hAAAB, 1'b0, 1'b0},
      '{16'h3000, 16'h4000, 16'h7FFF, 1'b1, 1'b0},
      '{16'hD000, 16'h4000, 16'h8000, 1'b1, 1'b0},
      '{16'hE000, 16'h4000, 16'h8000, 1'b0, 1'b0},
      '{16'h1234, 16'h0000, 16'h7FFF, 1'b0, 1'b1},
      '{16'h8000, 16'h0000, 16'h8000, 1'b0, 1'b1},
      '{16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1},
      '{16'h0000, 16'h1234, 16'h0000, 1'b0, 1'b0},
      '{16'h8000, 16'h8000, 16'h7FFF, 1'b1, 1'b0},
      '{16'h4000, 16'h8000, 16'h8000, 1'b0, 1'b0},
      '{16'h0001, 16'h7FFF, 16'h0002, 1'b0, 1'b0},
      '{16'h8000, 16'h0001, 16'h8000, 1'b1, 1'b0},
      '{16'h0001, 16'hFFFF, 16'h8000, 1'b1, 1'b0},
      '{16'h0100, 16'h7000, 16'h0249, 1'b0, 1'b0}
    };

    // reset state
    #1;
    chk("reset_outputs", 64'({quotient, busy, done, ovf, dz, st}), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_idle", 64'({quotient, busy, done, ovf, dz, st}), 64'd0);

    // directed table
    for (int i = 0; i < 17; i++) begin
      run_div(vecs[i].a, vecs[i].b, q, o, z);
      chk($sformatf("vec%0d_%h_%h", i, vecs[i].a, vecs[i].b),
          64'({z, o, q}), 64'({vecs[i].dz, vecs[i].ovf, vecs[i].q}));
    end

    // random against the reference model
    for (int i = 0; i < 60; i++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 5))
        0:       rb = 16'sd0;
        1:       rb = 16'($urandom_range(1, 7));
        2:       rb = -16'($urandom_range(1, 7));
        default: rb = 16'($urandom);
      endcase
      if ($urandom_range(0, 9) == 0) ra = 16'sd0;
      exp_q.push_back(model(ra, rb));
      run_div(ra, rb, q, o, z);
      e = exp_q.pop_front();
      chk($sformatf("rand_%h_%h", ra, rb), 64'({z, o, q}), 64'(e));
    end

    // start held high, operands changed during CALC
    @(negedge clk);
    start = 1'b1; dividend = 16'h1000; divisor = 16'h4000;
    @(negedge clk);
    dividend = 16'h0001; divisor = 16'h0003;
    nd = 0; t1 = -1; t2 = -1; q1 = '0; q2 = '0;
    for (c = 0; c < 80; c++) begin
      if (done) begin
        nd++;
        if (nd == 1) begin t1 = c; q1 = quotient; end
        else begin t2 = c; q2 = quotient; end
      end
      if (c == 34) chk("idle_after_done", 64'(busy), 64'd0);
      if (c == 35) start = 1'b0;
      @(negedge clk);
    end
    chk("hs_done_count", 64'(nd), 64'd2);
    chk("hs_first_time", 64'(t1), 64'd33);
    chk("hs_first_q", 64'(q1), 64'h4000);
    chk("hs_second_time", 64'(t2), 64'd68);
    chk("hs_second_q", 64'(q2), 64'h5555);

    // reset during CALC
    run_div(16'h1234, 16'h0000, q, o, z);
    chk("pre_reset_result", 64'({z, o, q}), 64'({1'b1, 1'b0, 16'h7FFF}));
    @(negedge clk);
    start = 1'b1; dividend = 16'h0001; divisor = 16'h0003;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("reset_mid_calc", 64'({quotient, busy, done, ovf, dz, st}), 64'd0);
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 2) rst = 1'b0;
      if (done) nd++;
    end
    chk("no_done_after_abort", 64'(nd), 64'd0);
    run_div(16'h1000, 16'h4000, q, o, z);
    chk("after_reset_result", 64'({z, o, q}), 64'({1'b0, 1'b0, 16'h4000}));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
